// File: rtl/issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: instruction entry, score_board
// read/write payload, scheduler FSM states and the operand readiness rule.
package issue_scheduler_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned POS_W = 8;

  typedef logic [REG_W-1:0] REG_ADDR;

  typedef struct packed {
    logic [POS_W-1:0] position;
  } SCORE_BOARD_DATA;

  typedef struct packed {
    REG_ADDR    src1;
    REG_ADDR    src2;
    REG_ADDR    dst;
    logic       has_dst;
    logic [2:0] lat;
    logic       is_mem;
    logic       serial;
  } ISSUE_INST;

  typedef enum logic [1:0] {
    RUN,
    SERIAL_WAIT,
    FLUSH
  } SCHED_STATE;

  // Bit 0 of position means the result is on the bypass network this cycle.
  function automatic logic operand_ready(input REG_ADDR addr, input SCORE_BOARD_DATA sb);
    return (addr == '0) || (sb.position[POS_W-1:1] == '0);
  endfunction

endpackage

// File: rtl/issue_scheduler_queue.sv
// Circular instruction FIFO: up to two pushes and two pops per cycle, with a
// peek of the head and head+1 entries and a synchronous clear.
module issue_queue
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [1:0]               push,
  input  ISSUE_INST [1:0]          push_data,
  input  logic [1:0]               pop_cnt,
  output ISSUE_INST [1:0]          peek,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  ISSUE_INST     mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] head1_idx, tail1_idx;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    head1_idx = head_q + 1'b1;
    tail1_idx = tail_q + 1'b1;
    head_d    = head_q + AW'(pop_cnt);
    tail_d    = tail_q + AW'(push[0]) + AW'(push[1]);
    count_d   = count_q + (AW+1)'(push[0]) + (AW+1)'(push[1]) - (AW+1)'(pop_cnt);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push[0] && !clear) mem_q[tail_q]    <= push_data[0];
    if (push[1] && !clear) mem_q[tail1_idx] <= push_data[1];
  end

  assign peek[0] = mem_q[head_q];
  assign peek[1] = mem_q[head1_idx];
  assign count   = count_q;

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: buffers decoded pairs, checks operand
// readiness against score_board and intra-pair hazards, and marks destinations.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned QDEPTH     = 8,
  parameter int unsigned SERIAL_GAP = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                in_valid,
  input  ISSUE_INST [1:0]           in_inst,
  output logic                      in_ready,
  output REG_ADDR [3:0]             sb_read_addr,
  input  SCORE_BOARD_DATA [3:0]     sb_data,
  output logic [1:0]                sb_write_ena,
  output REG_ADDR [1:0]             sb_write_addr,
  output SCORE_BOARD_DATA [1:0]     sb_write_data,
  input  logic                      exe_stall,
  input  logic                      flush,
  output logic [1:0]                issue_valid,
  output ISSUE_INST [1:0]           issue_inst,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned GW = $clog2(SERIAL_GAP + 1);

  SCHED_STATE      state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  ISSUE_INST [1:0] peek;
  logic [1:0]      push, iss, pop_cnt;
  logic            raw, waw;
  logic            sb_bypass_unused;

  assign in_ready = rst_n && (q_count <= CW'(QDEPTH - 2));
  assign push[0]  = in_valid[0] && in_ready && !flush;
  assign push[1]  = push[0] && in_valid[1];
  assign pop_cnt  = {1'b0, iss[0]} + {1'b0, iss[1]};

  issue_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (in_inst),
    .pop_cnt   (pop_cnt),
    .peek      (peek),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // The gap counter reaching zero is the last idle cycle, so exactly
  // SERIAL_GAP cycles pass between a serial issue and the next one.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (flush) begin
      state_d = FLUSH;
      gap_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (iss[0] && peek[0].serial) begin
            state_d = SERIAL_WAIT;
            gap_d   = GW'(SERIAL_GAP);
          end
        end
        SERIAL_WAIT: begin
          if (gap_q <= GW'(1)) begin
            state_d = RUN;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    raw = peek[0].has_dst && (peek[1].src1 == peek[0].dst || peek[1].src2 == peek[0].dst);
    waw = peek[0].has_dst && peek[1].has_dst && (peek[0].dst == peek[1].dst);
    iss = '0;
    iss[0] = rst_n && (q_count != '0) && (state_q == RUN) && !exe_stall && !flush
             && operand_ready(peek[0].src1, sb_data[0])
             && operand_ready(peek[0].src2, sb_data[1]);
    iss[1] = iss[0] && (q_count >= CW'(2))
             && operand_ready(peek[1].src1, sb_data[2])
             && operand_ready(peek[1].src2, sb_data[3])
             && !raw && !waw && !(peek[0].is_mem && peek[1].is_mem)
             && !peek[0].serial && !peek[1].serial;
  end

  always_comb begin
    sb_write_ena  = '0;
    sb_write_addr = '0;
    sb_write_data = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (iss[i] && peek[i].has_dst && (peek[i].dst != '0)) begin
        sb_write_ena[i]           = 1'b1;
        sb_write_addr[i]          = peek[i].dst;
        sb_write_data[i].position = POS_W'(1) << peek[i].lat;
      end
    end
  end

  assign sb_read_addr[0] = peek[0].src1;
  assign sb_read_addr[1] = peek[0].src2;
  assign sb_read_addr[2] = peek[1].src1;
  assign sb_read_addr[3] = peek[1].src2;
  assign issue_valid     = iss;
  assign issue_inst      = peek;

  assign sb_bypass_unused = ^{sb_data[0].position[0], sb_data[1].position[0],
                              sb_data[2].position[0], sb_data[3].position[0]};

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: stimulus queues expected issue events,
// a negedge monitor pops and compares them whenever the DUT issues.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int unsigned QDEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            in_valid;
  ISSUE_INST [1:0]       in_inst;
  logic                  in_ready;
  REG_ADDR [3:0]         sb_read_addr;
  SCORE_BOARD_DATA [3:0] sb_data;
  logic [1:0]            sb_write_ena;
  REG_ADDR [1:0]         sb_write_addr;
  SCORE_BOARD_DATA [1:0] sb_write_data;
  logic                  exe_stall;
  logic                  flush;
  logic [1:0]            issue_valid;
  ISSUE_INST [1:0]       issue_inst;
  logic [3:0]            q_count;

  always #5 clk = ~clk;

  issue_scheduler #(.QDEPTH(QDEPTH), .SERIAL_GAP(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_inst       (in_inst),
    .in_ready      (in_ready),
    .sb_read_addr  (sb_read_addr),
    .sb_data       (sb_data),
    .sb_write_ena  (sb_write_ena),
    .sb_write_addr (sb_write_addr),
    .sb_write_data (sb_write_data),
    .exe_stall     (exe_stall),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_inst    (issue_inst),
    .q_count       (q_count)
  );

  // score_board stand-in: a written position counts as the first shift, so a
  // latency-N result becomes bypass-ready N cycles after its producer issues.
  logic [7:0] sbpos [32];

  always @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (!rst_n)
        sbpos[r] <= '0;
      else if (sb_write_ena[0] && sb_write_addr[0] == 5'(r))
        sbpos[r] <= sb_write_data[0].position >> 1;
      else if (sb_write_ena[1] && sb_write_addr[1] == 5'(r))
        sbpos[r] <= sb_write_data[1].position >> 1;
      else
        sbpos[r] <= sbpos[r] >> 1;
    end
  end

  always_comb begin
    sb_data = '0;
    for (int i = 0; i < 4; i++) sb_data[i].position = sbpos[sb_read_addr[i]];
  end

  typedef struct {
    int         cyc;
    logic [1:0] valid;
    logic [1:0] ena;
    int         a0;
    int         p0;
    int         a1;
    int         p1;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic ISSUE_INST mk(input int s1, input int s2, input int d, input logic hd,
                                   input int lat, input logic mem, input logic ser);
    ISSUE_INST x;
    x.src1    = REG_ADDR'(s1);
    x.src2    = REG_ADDR'(s2);
    x.dst     = REG_ADDR'(d);
    x.has_dst = hd;
    x.lat     = 3'(lat);
    x.is_mem  = mem;
    x.serial  = ser;
    return x;
  endfunction

  task automatic expect_issue(input int cy, input logic [1:0] v, input logic [1:0] e,
                              input int a0, input int p0, input int a1, input int p1);
    exp_t x;
    x.cyc = cy; x.valid = v; x.ena = e;
    x.a0 = a0; x.p0 = p0; x.a1 = a1; x.p1 = p1;
    expq.push_back(x);
  endtask

  task automatic push2(input ISSUE_INST a, input ISSUE_INST b, input logic two);
    in_inst[0] = a;
    in_inst[1] = b;
    in_valid   = {two, 1'b1};
    @(posedge clk); #1;
    in_valid   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && issue_valid != 2'b00) begin
      if (expq.size() == 0) begin
        chk("unexpected_issue", 32'(issue_valid), 32'h0);
      end else begin
        mon_e = expq.pop_front();
        chk("issue_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("issue_valid", 32'(issue_valid), 32'(mon_e.valid));
        chk("sb_write_ena", 32'(sb_write_ena), 32'(mon_e.ena));
        if (mon_e.ena[0]) begin
          chk("sb_write_addr0", 32'(sb_write_addr[0]), 32'(mon_e.a0));
          chk("sb_write_pos0", 32'(sb_write_data[0].position), 32'(mon_e.p0));
        end
        if (mon_e.ena[1]) begin
          chk("sb_write_addr1", 32'(sb_write_addr[1]), 32'(mon_e.a1));
          chk("sb_write_pos1", 32'(sb_write_data[1].position), 32'(mon_e.p1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    ISSUE_INST nop;
    nop       = mk(0, 0, 0, 1'b0, 1, 1'b0, 1'b0);
    rst_n     = 1'b0;
    in_valid  = '0;
    in_inst   = '0;
    exe_stall = 1'b0;
    flush     = 1'b0;
    #3;
    chk("reset_q_count", 32'(q_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_issue_valid", 32'(issue_valid), 32'd0);
    chk("reset_sb_ena", 32'(sb_write_ena), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // independent pair
    c = cyc;
    expect_issue(c + 1, 2'b11, 2'b11, 3, 8'h02, 4, 8'h02);
    push2(mk(1, 2, 3, 1'b1, 1, 1'b0, 1'b0), mk(5, 6, 4, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    idle(3);

    // RAW inside the pair: consumer waits for the lat-3 load
    c = cyc;
    expect_issue(c + 1, 2'b01, 2'b01, 3, 8'h08, 0, 0);
    expect_issue(c + 4, 2'b01, 2'b01, 5, 8'h02, 0, 0);
    push2(mk(1, 2, 3, 1'b1, 3, 1'b1, 1'b0), mk(3, 1, 5, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    idle(6);

    // two memory ops issue singly
    c = cyc;
    expect_issue(c + 1, 2'b01, 2'b01, 7, 8'h04, 0, 0);
    expect_issue(c + 2, 2'b01, 2'b00, 0, 0, 0, 0);
    push2(mk(1, 2, 7, 1'b1, 2, 1'b1, 1'b0), mk(1, 2, 0, 1'b0, 1, 1'b1, 1'b0), 1'b1);
    chk("mem_q_count_2", 32'(q_count), 32'd2);
    idle(1);
    chk("mem_q_count_1", 32'(q_count), 32'd1);
    idle(1);
    chk("mem_q_count_0", 32'(q_count), 32'd0);
    idle(2);

    // serialising head: 7 idle cycles before the follower
    c = cyc;
    expect_issue(c + 1, 2'b01, 2'b01, 8, 8'h02, 0, 0);
    expect_issue(c + 9, 2'b01, 2'b01, 9, 8'h02, 0, 0);
    push2(mk(0, 0, 8, 1'b1, 1, 1'b0, 1'b1), mk(1, 2, 9, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    idle(12);

    // fill under stall, then flush
    exe_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      push2(mk(1, 2, 10 + 2 * i, 1'b1, 1, 1'b0, 1'b0), mk(1, 2, 11 + 2 * i, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    chk("full_q_count", 32'(q_count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push2(nop, nop, 1'b1);
    chk("full_push_ignored", 32'(q_count), 32'd8);
    flush      = 1'b1;
    in_inst[0] = nop;
    in_inst[1] = nop;
    in_valid   = 2'b11;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = '0;
    chk("flush_q_count", 32'(q_count), 32'd0);
    chk("flush_issue_valid", 32'(issue_valid), 32'd0);
    chk("flush_sb_ena", 32'(sb_write_ena), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    exe_stall = 1'b0;
    idle(3);
    chk("flush_push_dropped", 32'(q_count), 32'd0);

    // asynchronous reset with 5 entries queued
    exe_stall = 1'b1;
    push2(mk(1, 2, 12, 1'b1, 1, 1'b0, 1'b0), mk(1, 2, 13, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    push2(mk(1, 2, 14, 1'b1, 1, 1'b0, 1'b0), mk(1, 2, 15, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    push2(mk(1, 2, 16, 1'b1, 1, 1'b0, 1'b0), nop, 1'b0);
    chk("pre_reset_q_count", 32'(q_count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q_count", 32'(q_count), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_issue_valid", 32'(issue_valid), 32'd0);
    chk("async_sb_ena", 32'(sb_write_ena), 32'd0);
    exe_stall = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_async_q_count", 32'(q_count), 32'd0);
    chk("post_async_in_ready", 32'(in_ready), 32'd1);
    idle(2);

    // odd offset so the last pair straddles the wrap (entries 7 and 0)
    c = cyc;
    expect_issue(c + 1, 2'b01, 2'b01, 20, 8'h02, 0, 0);
    push2(mk(1, 2, 20, 1'b1, 1, 1'b0, 1'b0), nop, 1'b0);
    for (int i = 0; i < 4; i++) begin
      c = cyc;
      expect_issue(c + 1, 2'b11, 2'b11, 21 + 2 * i, 8'h02, 22 + 2 * i, 8'h02);
      push2(mk(1, 2, 21 + 2 * i, 1'b1, 1, 1'b0, 1'b0), mk(1, 2, 22 + 2 * i, 1'b1, 1, 1'b0, 1'b0), 1'b1);
    end
    idle(2);
    chk("wrap_q_count", 32'(q_count), 32'd0);

    for (int i = 0; i < 20 && expq.size() != 0; i++) idle(1);
    while (expq.size() != 0) begin
      mon_e = expq.pop_front();
      chk("missing_issue", 32'hFFFF_FFFF, 32'(mon_e.cyc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
